// File: rtl/boid_refill_ctrl.sv
// boid_refill_ctrl: redraws every boid into VGA pixel memory after an update pass.
// Define BOID_ERASE_EN to erase each boid's previous pixel before it is redrawn.
module boid_refill_ctrl #(
  parameter int num_boids = 2,
  parameter int COORD_W = 16,
  parameter int SCR_W = 640,
  parameter int SCR_H = 480,
  parameter logic [7:0] BOID_COLOR = 8'hFF,
  parameter logic [7:0] BG_COLOR = 8'h00,
  localparam int IW = (num_boids > 1) ? $clog2(num_boids) : 1
) (
  input  logic clk,
  input  logic reset,
  input  logic start,
  output logic [IW-1:0] bd_rd_addr,
  output logic bd_rd_en,
  input  logic signed [COORD_W-1:0] bd_x,
  input  logic signed [COORD_W-1:0] bd_y,
  output logic [18:0] pix_addr,
  output logic [7:0] pix_data,
  output logic pix_we,
  input  logic pix_ready,
  output logic is_refilling,
  output logic done
);

  typedef enum logic [2:0] {
    S_IDLE, S_RD_REQ, S_RD_WAIT, S_ADDR,
    S_ERASE, S_DRAW, S_NEXT, S_DONE
  } state_e;

  localparam logic [IW-1:0] LAST = IW'(num_boids - 1);

  state_e state_q, state_d;
  logic [IW-1:0] idx_q, idx_d;
  logic signed [COORD_W-1:0] x_q, x_d, y_q, y_d;
  logic [18:0] addr_q, addr_d;
  logic inr_q, inr_d;

  logic signed [18:0] x19, y19;
  logic [18:0] new_addr;
  logic in_range;

  assign x19 = 19'(x_q);
  assign y19 = 19'(y_q);

  assign in_range = (int'(x_q) >= 0) && (int'(x_q) < SCR_W) &&
                    (int'(y_q) >= 0) && (int'(y_q) < SCR_H);

  if (SCR_W == 640) begin : g_a640
    assign new_addr = (y19 << 9) + (y19 << 7) + x19;
  end else begin : g_agen
    assign new_addr = y19 * 19'(SCR_W) + x19;
  end

  assign bd_rd_addr = idx_q;
  assign is_refilling = (state_q != S_IDLE);

`ifdef BOID_ERASE_EN
  logic [18:0] old_addr_q [num_boids];
  logic [num_boids-1:0] old_valid_q;

  // Remember where each boid was drawn so the next pass can erase it
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      old_valid_q <= '0;
      for (int i = 0; i < num_boids; i++) old_addr_q[i] <= '0;
    end else if (state_q == S_NEXT) begin
      old_addr_q[idx_q] <= addr_q;
      old_valid_q[idx_q] <= inr_q;
    end
  end
`endif

  // State and walk registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      idx_q <= '0;
      x_q <= '0;
      y_q <= '0;
      addr_q <= '0;
      inr_q <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q <= idx_d;
      x_q <= x_d;
      y_q <= y_d;
      addr_q <= addr_d;
      inr_q <= inr_d;
    end
  end

  // Next state and outputs; outputs are decoded from registered state only
  always_comb begin
    state_d = state_q;
    idx_d = idx_q;
    x_d = x_q;
    y_d = y_q;
    addr_d = addr_q;
    inr_d = inr_q;
    bd_rd_en = 1'b0;
    pix_we = 1'b0;
    pix_addr = '0;
    pix_data = '0;
    done = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (start) state_d = S_RD_REQ;
      end
      S_RD_REQ: begin
        bd_rd_en = 1'b1;
        state_d = S_RD_WAIT;
      end
      S_RD_WAIT: begin
        x_d = bd_x;
        y_d = bd_y;
        state_d = S_ADDR;
      end
      S_ADDR: begin
        inr_d = in_range;
        addr_d = new_addr;
        state_d = S_ERASE;
      end
      S_ERASE: begin
        state_d = S_DRAW;
`ifdef BOID_ERASE_EN
        if (old_valid_q[idx_q]) begin
          pix_we = 1'b1;
          pix_addr = old_addr_q[idx_q];
          pix_data = BG_COLOR;
          if (!pix_ready) state_d = S_ERASE;
        end
`endif
      end
      S_DRAW: begin
        state_d = S_NEXT;
        if (inr_q) begin
          pix_we = 1'b1;
          pix_addr = addr_q;
          pix_data = BOID_COLOR;
          if (!pix_ready) state_d = S_DRAW;
        end
      end
      S_NEXT: begin
        if (idx_q == LAST) begin
          idx_d = '0;
          state_d = S_DONE;
        end else begin
          idx_d = idx_q + 1'b1;
          state_d = S_RD_REQ;
        end
      end
      S_DONE: begin
        done = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_boid_refill_ctrl.sv
// tb_boid_refill_ctrl: randomized refills checked against a queue-based pixel model.
// Covers reset, ranges, back-pressure, ignored starts and mid-refill reset.
module tb_boid_refill_ctrl;

  localparam int NB = 2;

  logic clk = 1'b0;
  logic reset;
  logic start;
  logic [0:0] bd_rd_addr;
  logic bd_rd_en;
  logic [15:0] bd_x, bd_y;
  logic [18:0] pix_addr;
  logic [7:0] pix_data;
  logic pix_we;
  logic pix_ready;
  logic is_refilling;
  logic done;

  boid_refill_ctrl dut (
    .clk(clk), .reset(reset), .start(start),
    .bd_rd_addr(bd_rd_addr), .bd_rd_en(bd_rd_en),
    .bd_x(bd_x), .bd_y(bd_y),
    .pix_addr(pix_addr), .pix_data(pix_data),
    .pix_we(pix_we), .pix_ready(pix_ready),
    .is_refilling(is_refilling), .done(done)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  int mem_x [NB];
  int mem_y [NB];
  int m_old_addr [NB];
  bit m_old_valid [NB];

  // boid memory: data valid only the cycle after a read strobe
  always @(posedge clk) begin
    if (bd_rd_en) begin
      bd_x <= 16'(mem_x[bd_rd_addr]);
      bd_y <= 16'(mem_y[bd_rd_addr]);
    end else begin
      bd_x <= 16'($urandom);
      bd_y <= 16'($urandom);
    end
  end

  int rdy_mode = 0;
  int stall_left = 0;
  bit spur_en = 0;

  // pixel sink back-pressure
  always @(posedge clk) begin
    #1;
    case (rdy_mode)
      1: pix_ready = ($urandom % 3) != 0;
      2: begin
        if (pix_we && stall_left > 0) begin
          pix_ready = 1'b0;
          stall_left--;
        end else begin
          pix_ready = 1'b1;
        end
      end
      default: pix_ready = 1'b1;
    endcase
  end

  task automatic model_reset();
    for (int i = 0; i < NB; i++) begin
      m_old_valid[i] = 0;
      m_old_addr[i] = 0;
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    model_reset();
  endtask

  task automatic do_refill(input string nm, input int exp_stalls);
    int ea[$], ed[$], oa[$], od[$];
    int cyc, done_cyc, ndone, hi, stalls;
    bit pstall;
    logic [18:0] paddr;
    logic [7:0] pdata;
    for (int i = 0; i < NB; i++) begin
`ifdef BOID_ERASE_EN
      if (m_old_valid[i]) begin
        ea.push_back(m_old_addr[i]);
        ed.push_back(8'h00);
      end
`endif
      if (mem_x[i] >= 0 && mem_x[i] < 640 &&
          mem_y[i] >= 0 && mem_y[i] < 480) begin
        ea.push_back(mem_y[i] * 640 + mem_x[i]);
        ed.push_back(8'hFF);
        m_old_valid[i] = 1;
        m_old_addr[i] = mem_y[i] * 640 + mem_x[i];
      end else begin
        m_old_valid[i] = 0;
      end
    end
    @(posedge clk);
    #1 start = 1'b1;
    cyc = 0;
    done_cyc = -1;
    ndone = 0;
    hi = 0;
    stalls = 0;
    pstall = 0;
    paddr = '0;
    pdata = '0;
    while (cyc < 400) begin
      @(negedge clk);
      if (pstall) begin
        check({nm, "_hold_we"}, 32'(pix_we), 1);
        check({nm, "_hold_addr"}, 32'(pix_addr), 32'(paddr));
        check({nm, "_hold_data"}, 32'(pix_data), 32'(pdata));
      end
      pstall = pix_we && !pix_ready;
      paddr = pix_addr;
      pdata = pix_data;
      if (pstall) stalls++;
      if (pix_we && pix_ready) begin
        oa.push_back(int'(pix_addr));
        od.push_back(int'(pix_data));
      end
      if (is_refilling) hi++;
      if (done) begin
        ndone++;
        if (done_cyc < 0) done_cyc = cyc;
      end
      if (done_cyc >= 0 && cyc > done_cyc) break;
      @(posedge clk);
      #1 start = spur_en && is_refilling && !done && ($urandom % 4 == 0);
      cyc++;
    end
    start = 1'b0;
    if (done_cyc < 0) begin
      check({nm, "_timeout"}, 1, 0);
    end else begin
      check({nm, "_done_cyc"}, done_cyc, 13 + stalls);
      check({nm, "_ndone"}, ndone, 1);
      check({nm, "_refill_hi"}, hi, 13 + stalls);
      check({nm, "_refill_end"}, 32'(is_refilling), 0);
    end
    if (exp_stalls >= 0) check({nm, "_stalls"}, stalls, exp_stalls);
    check({nm, "_nxfer"}, oa.size(), ea.size());
    for (int i = 0; i < ea.size() && i < oa.size(); i++) begin
      check({nm, "_xaddr"}, oa[i], ea[i]);
      check({nm, "_xdata"}, od[i], ed[i]);
    end
  endtask

  initial begin
    reset = 1'b1;
    start = 1'b0;
    pix_ready = 1'b1;
    model_reset();
    for (int i = 0; i < NB; i++) begin
      mem_x[i] = 0;
      mem_y[i] = 0;
    end
    #1;
    check("reset_out", {pix_we, done, is_refilling, bd_rd_en,
                        bd_rd_addr, pix_data, pix_addr}, 0);
    do_reset();
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("idle_out", {pix_we, done, is_refilling, bd_rd_en,
                         bd_rd_addr, pix_data, pix_addr}, 0);
    end

    mem_x[0] = 10; mem_y[0] = 20;
    mem_x[1] = 639; mem_y[1] = 479;
    do_refill("basic", 0);

    mem_x[0] = -1; mem_y[0] = 5;
    mem_x[1] = 640; mem_y[1] = 0;
    do_refill("oor_x", 0);

    mem_x[0] = 0; mem_y[0] = 480;
    mem_x[1] = 0; mem_y[1] = -1;
    do_refill("oor_y", 0);

    do_reset();
    mem_x[0] = 100; mem_y[0] = 7;
    mem_x[1] = 700; mem_y[1] = 7;
    rdy_mode = 2;
    stall_left = 4;
    do_refill("stall", 4);
    rdy_mode = 0;

    do_reset();
    mem_x[0] = 1; mem_y[0] = 1;
    mem_x[1] = -5; mem_y[1] = 1;
    do_refill("move1", 0);
    mem_x[0] = 2;
    do_refill("move2", 0);

    mem_x[0] = 10; mem_y[0] = 20;
    mem_x[1] = 639; mem_y[1] = 479;
    @(posedge clk);
    #1 start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (bd_rd_en && bd_rd_addr == 1'b1) break;
    end
    check("mid_seen_rd1", {31'd0, bd_rd_en}, 1);
    @(posedge clk);
    #2 reset = 1'b1;
    #1;
    check("mid_async_out", {pix_we, done, is_refilling, bd_rd_en,
                            bd_rd_addr, pix_data, pix_addr}, 0);
    @(negedge clk);
    reset = 1'b0;
    model_reset();
    @(negedge clk);
    check("mid_idle_out", {pix_we, done, is_refilling, bd_rd_en,
                           bd_rd_addr, pix_data, pix_addr}, 0);
    do_refill("after_rst", 0);

    spur_en = 1;
    for (int r = 0; r < 25; r++) begin
      rdy_mode = $urandom % 2;
      for (int i = 0; i < NB; i++) begin
        mem_x[i] = int'($urandom_range(0, 700)) - 30;
        mem_y[i] = int'($urandom_range(0, 540)) - 30;
      end
      do_refill("rand", -1);
    end
    spur_en = 0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

endmodule

// File: doc/boid_refill_ctrl.md
Name: boid_refill_ctrl

Overview:
- Frame-redraw stage downstream of the boid accelerator controller.
- After each update pass it walks all boids, reads each position from boid state memory, converts it to a VGA M10K pixel address, and writes the boid colour.
- Drives is_refilling back to the accelerator controller so no update pass starts while a redraw is in flight.

Parameters:
- num_boids, 2, number of boids walked per refill.
- COORD_W, 16, width of the signed integer-pixel coordinate inputs.
- SCR_W, 640, screen width in pixels; x valid range 0..SCR_W-1.
- SCR_H, 480, screen height in pixels; y valid range 0..SCR_H-1.
- BOID_COLOR, 8'hFF, pixel value written for a boid.
- BG_COLOR, 8'h00, pixel value used for erase.

Ports:
- clk  in  1  system clock; all state on rising edge.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle request to begin a refill; ignored unless in IDLE.
- bd_rd_addr  out  $clog2(num_boids)  boid index being read.
- bd_rd_en  out  1  read strobe to boid state memory; data returns exactly 1 cycle later.
- bd_x  in  COORD_W  signed x of the addressed boid.
- bd_y  in  COORD_W  signed y of the addressed boid.
- pix_addr  out  19  linear VGA M10K address, y*SCR_W + x.
- pix_data  out  8  pixel value.
- pix_we  out  1  write valid; held until accepted.
- pix_ready  in  1  M10K write port ready; a transfer occurs when pix_we && pix_ready.
- is_refilling  out  1  high from the cycle after start is accepted through the DONE cycle inclusive.
- done  out  1  one-cycle pulse in DONE.

Behaviour:
- Reset values: all outputs 0, idx=0, state IDLE, all old_valid bits 0.
- Reset mid-operation aborts immediately and pix_we drops asynchronously. No partial write is retried.
- States and transitions:
  - IDLE -> RD_REQ on start.
  - RD_REQ: bd_rd_en=1, bd_rd_addr=idx. Next state RD_WAIT.
  - RD_WAIT: capture bd_x/bd_y at the end of this cycle. Next state ADDR.
  - ADDR: in_range = (x>=0 && x<SCR_W && y>=0 && y<SCR_H), signed compares. new_addr = (y<<9)+(y<<7)+x when SCR_W=640 (generic multiply otherwise), truncated to 19 bits and registered. Next state ERASE.
  - ERASE: see Optional Feature. Next state DRAW.
  - DRAW: if in_range, pix_we=1, pix_addr=new_addr, pix_data=BOID_COLOR; stall until pix_ready. If out of range, no write and a 1-cycle pass. Next state NEXT.
  - NEXT: old_addr[idx]<=new_addr; old_valid[idx]<=in_range. If idx==num_boids-1, go to DONE with idx<=0; else idx<=idx+1 and go to RD_REQ.
  - DONE: done=1. Next state IDLE; is_refilling falls on the IDLE cycle.
- pix_addr, pix_data and pix_we must stay stable while pix_we=1 and pix_ready=0.
- start asserted during a refill has no effect and is not queued.
- Throughput with pix_ready tied high: 6 cycles per boid, so total = 1 + 6*num_boids + 1 cycles from start to is_refilling low.
- Boundary values: x=-1, x=640, y=480 are all out of range and produce no write. x=639, y=479 gives address 307199.

Optional Feature:
- Macro: BOID_ERASE_EN.
- Defined:
  - Per-boid old_addr/old_valid registers exist.
  - In ERASE, if old_valid[idx], write BG_COLOR to old_addr[idx] with the same handshake as DRAW.
  - The erase happens even when the old and new addresses are equal; DRAW follows, so the final pixel value is BOID_COLOR.
  - If old_valid[idx] is 0, ERASE is a 1-cycle pass.
- Not defined:
  - old_addr/old_valid registers are not built.
  - ERASE is a 1-cycle pass that never asserts pix_we. Cycle counts are unchanged.

Test Plan:
- Reset, then idle for 10 cycles -> all outputs 0; is_refilling stays 0.
- num_boids=2, boid0=(10,20), boid1=(639,479), pix_ready=1, start pulse -> writes 0x00FF at addr 12810, then 0xFF at addr 307199; done pulses at cycle 13 after start; is_refilling is high for cycles 1-13.
- boid0=(-1,5), boid1=(640,0) -> no pix_we for either boid; done still pulses and is_refilling still deasserts.
- pix_ready held low 4 cycles during DRAW of boid0 -> pix_we, pix_addr and pix_data stay stable for all 4 cycles; exactly one transfer; done is delayed by 4 cycles.
- BOID_ERASE_EN defined: refill 1 with boid0 at (1,1), then refill 2 with boid0 at (2,1) -> refill 2 writes BG_COLOR at addr 641, then BOID_COLOR at addr 642. Repeat without the macro -> only the addr-642 write occurs.
- Assert reset during the RD_WAIT of boid1, then pulse start -> returns to IDLE with outputs 0; the fresh refill starts at idx 0 and behaves exactly as in the second scenario.
